// File: rtl/fifo_pkg.sv
// Shared definitions for the sync_fifo_flags buffering primitive.
//   FIFO_MODE_STD  : registered read data, dout_valid is a one-cycle strobe
//   FIFO_MODE_FWFT : head word presented combinationally, dout_valid = !empty
//   level_width()  : bit width of the fill-level count (must hold 0..DEPTH)
package fifo_pkg;

   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   function automatic int level_width(input int log2_depth);
      return log2_depth + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for sync_fifo_flags: DEPTH x DATA_WIDTH flops.
//   clk     : write clock
//   wr_en   : write strobe (already qualified as an accepted write)
//   wr_addr : write address
//   din     : write data
//   rd_addr : read address (asynchronous read)
//   rd_data : contents at rd_addr
// Contents are intentionally not reset.
module fifo_mem #(
   parameter int DATA_WIDTH = 16,
   parameter int LOG2_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [LOG2_DEPTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic [LOG2_DEPTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [2**LOG2_DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= din;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with selectable standard / first-word-fall-through read,
// programmable almost-full / almost-empty thresholds, fill level and
// overflow / underflow error pulses.
//   clk, reset         : clock, synchronous active-high reset
//   din, wr_en         : write data / request
//   rd_en              : read request (FWFT: acknowledge of the shown word)
//   dout, dout_valid   : read data and its qualifier
//   full, empty        : level == DEPTH / level == 0
//   almost_full        : level >= AFULL_LEVEL
//   almost_empty       : level <= AEMPTY_LEVEL
//   level              : stored word count 0..DEPTH
//   overflow/underflow : one-cycle pulse after a rejected write / read
module sync_fifo_flags
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int LOG2_DEPTH   = 4,
   parameter int FWFT         = FIFO_MODE_STD,
   parameter int AFULL_LEVEL  = (2**LOG2_DEPTH) - 2,
   parameter int AEMPTY_LEVEL = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [DATA_WIDTH-1:0]              din,
   input  logic                               wr_en,
   input  logic                               rd_en,
   output logic [DATA_WIDTH-1:0]              dout,
   output logic                               dout_valid,
   output logic                               full,
   output logic                               empty,
   output logic                               almost_full,
   output logic                               almost_empty,
   output logic [level_width(LOG2_DEPTH)-1:0] level,
   output logic                               overflow,
   output logic                               underflow
);

   localparam int DEPTH = 2**LOG2_DEPTH;
   localparam int LW    = level_width(LOG2_DEPTH);

   localparam logic [LW-1:0] LVL_FULL   = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_AFULL  = LW'(AFULL_LEVEL);
   localparam logic [LW-1:0] LVL_AEMPTY = LW'(AEMPTY_LEVEL);

   generate
      if (LOG2_DEPTH < 1 || LOG2_DEPTH > 12) begin : g_bad_depth
         $error("sync_fifo_flags: LOG2_DEPTH must be in 1..12");
      end
      if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
         $error("sync_fifo_flags: FWFT must be 0 or 1");
      end
      if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
         $error("sync_fifo_flags: AFULL_LEVEL must be in 1..DEPTH");
      end
      if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > DEPTH - 1) begin : g_bad_aempty
         $error("sync_fifo_flags: AEMPTY_LEVEL must be in 0..DEPTH-1");
      end
   endgenerate

   logic [LOG2_DEPTH-1:0] wr_ptr;
   logic [LOG2_DEPTH-1:0] rd_ptr;
   logic [LW-1:0]         level_q;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_acc;
   logic                  wr_acc;
   logic                  overflow_q;
   logic                  underflow_q;

   assign empty        = (level_q == '0);
   assign full         = (level_q == LVL_FULL);
   assign almost_full  = (level_q >= LVL_AFULL);
   assign almost_empty = (level_q <= LVL_AEMPTY);
   assign level        = level_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // A write into a full FIFO is only safe when the head is leaving in the
   // same cycle; an empty FIFO never accepts a read, even with a write.
   assign rd_acc = rd_en && !empty;
   assign wr_acc = wr_en && (!full || rd_acc);

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .LOG2_DEPTH (LOG2_DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr),
      .din     (din),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + LOG2_DEPTH'(1);
         end
         case ({wr_acc, rd_acc})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
         overflow_q  <= wr_en && !wr_acc;
         underflow_q <= rd_en && !rd_acc;
      end
   end

   generate
      if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
         assign dout       = empty ? '0 : rd_data;
         assign dout_valid = !empty;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] dout_q;
         logic                  dout_valid_q;

         // rd_data is the pre-write head even when full with a simultaneous
         // write, because the array updates on the same edge we capture.
         always_ff @(posedge clk) begin
            if (reset) begin
               dout_q       <= '0;
               dout_valid_q <= 1'b0;
            end else begin
               dout_valid_q <= rd_acc;
               if (rd_acc) begin
                  dout_q <= rd_data;
               end
            end
         end

         assign dout       = dout_q;
         assign dout_valid = dout_valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

   localparam int DW    = 16;
   localparam int L2D   = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] din = '0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;

   logic [DW-1:0] s_dout, f_dout;
   logic          s_dv, f_dv, s_full, f_full, s_empty, f_empty;
   logic          s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_udf, f_udf;
   logic [L2D:0]  s_level, f_level;

   int n_cmp = 0;
   int n_mis = 0;

   // reference model state
   logic [DW-1:0] q[$];
   logic [DW-1:0] exp_std_dout = '0;
   logic          exp_std_dv = 1'b0;
   logic          exp_ovf = 1'b0;
   logic          exp_udf = 1'b0;

   always #5 clk = ~clk;

   sync_fifo_flags #(.DATA_WIDTH(DW), .LOG2_DEPTH(L2D), .FWFT(0)) u_std (
      .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
      .dout(s_dout), .dout_valid(s_dv), .full(s_full), .empty(s_empty),
      .almost_full(s_af), .almost_empty(s_ae), .level(s_level),
      .overflow(s_ovf), .underflow(s_udf)
   );

   sync_fifo_flags #(.DATA_WIDTH(DW), .LOG2_DEPTH(L2D), .FWFT(1)) u_fwft (
      .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
      .dout(f_dout), .dout_valid(f_dv), .full(f_full), .empty(f_empty),
      .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
      .overflow(f_ovf), .underflow(f_udf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      int sz;
      sz = q.size();
      check("std_level",  32'(s_level), 32'(sz));
      check("fwft_level", 32'(f_level), 32'(sz));
      check("std_full",   32'(s_full),  32'(sz == DEPTH));
      check("fwft_full",  32'(f_full),  32'(sz == DEPTH));
      check("std_empty",  32'(s_empty), 32'(sz == 0));
      check("fwft_empty", 32'(f_empty), 32'(sz == 0));
      check("std_afull",  32'(s_af),    32'(sz >= DEPTH - 2));
      check("fwft_afull", 32'(f_af),    32'(sz >= DEPTH - 2));
      check("std_aempty", 32'(s_ae),    32'(sz <= 1));
      check("fwft_aempty",32'(f_ae),    32'(sz <= 1));
      check("std_ovf",    32'(s_ovf),   32'(exp_ovf));
      check("fwft_ovf",   32'(f_ovf),   32'(exp_ovf));
      check("std_udf",    32'(s_udf),   32'(exp_udf));
      check("fwft_udf",   32'(f_udf),   32'(exp_udf));
      check("std_dout",   32'(s_dout),  32'(exp_std_dout));
      check("std_dv",     32'(s_dv),    32'(exp_std_dv));
      check("fwft_dout",  32'(f_dout),  (sz > 0) ? 32'(q[0]) : 32'h0);
      check("fwft_dv",    32'(f_dv),    32'(sz > 0));
   endtask

   // One clock: drive inputs, advance the model on the edge, check after it.
   task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
      logic          racc, wacc;
      logic [DW-1:0] head;
      wr_en = w;
      rd_en = r;
      din   = d;
      reset = rs;
      @(posedge clk);
      if (rs) begin
         q.delete();
         exp_std_dout = '0;
         exp_std_dv   = 1'b0;
         exp_ovf      = 1'b0;
         exp_udf      = 1'b0;
      end else begin
         racc = r && (q.size() > 0);
         wacc = w && ((q.size() < DEPTH) || racc);
         head = '0;
         if (racc) head = q.pop_front();
         if (wacc) q.push_back(d);
         exp_ovf    = w && !wacc;
         exp_udf    = r && !racc;
         exp_std_dv = racc;
         if (racc) exp_std_dout = head;
      end
      #1;
      check_all();
   endtask

   initial begin
      logic w, r;
      // reset with live inputs, which must be ignored
      cycle(1'b1, 1'b1, 16'h5555, 1'b1);
      cycle(1'b0, 1'b0, 16'h0, 1'b1);

      // fill with 0x0001..0x0010, then a rejected write while full
      for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, 16'(i), 1'b0);
      check("full_after_16", 32'(s_full), 32'h1);
      cycle(1'b1, 1'b0, 16'h7777, 1'b0);
      check("ovf_pulse", 32'(s_ovf), 32'h1);
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      check("ovf_cleared", 32'(s_ovf), 32'h0);

      // drain in order, then read while empty
      for (int i = 1; i <= DEPTH; i++) begin
         cycle(1'b0, 1'b1, 16'h0, 1'b0);
         check("drain_order", 32'(s_dout), 32'(i));
      end
      cycle(1'b0, 1'b1, 16'h0, 1'b0);
      check("udf_pulse", 32'(s_udf), 32'h1);
      cycle(1'b1, 1'b1, 16'h1234, 1'b0);
      check("rdwr_empty_level", 32'(s_level), 32'h1);
      cycle(1'b0, 1'b1, 16'h0, 1'b0);

      // full with simultaneous read+write of 0xBEEF
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 16'h0100 + 16'(i), 1'b0);
      cycle(1'b1, 1'b1, 16'hBEEF, 1'b0);
      check("full_rdwr_oldest", 32'(s_dout), 32'h0100);
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 16'h0, 1'b0);
      check("last_is_beef", 32'(s_dout), 32'hBEEF);

      // FWFT fall-through of a single word
      cycle(1'b1, 1'b0, 16'hA5A5, 1'b0);
      check("fwft_show", 32'(f_dout), 32'hA5A5);
      cycle(1'b0, 1'b1, 16'h0, 1'b0);
      check("fwft_pop_empty", 32'(f_empty), 32'h1);

      // interleaved traffic kept in the 3..12 band, crossing the pointer wrap
      for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 16'($urandom), 1'b0);
      for (int i = 0; i < 80; i++) begin
         w = 1'($urandom);
         r = 1'($urandom);
         if (q.size() >= 12) w = 1'b0;
         if (q.size() <= 3)  r = 1'b0;
         cycle(w, r, 16'($urandom), 1'b0);
      end

      // reset mid-stream
      cycle(1'b1, 1'b1, 16'hFFFF, 1'b1);
      check("rst_mid_level", 32'(s_level), 32'h0);

      // unconstrained traffic, biased to hit full and empty boundaries
      for (int i = 0; i < 200; i++) begin
         if ((i / 40) % 2 == 0) begin
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) == 0);
         end else begin
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) != 0);
         end
         cycle(w, r, 16'($urandom), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
